// File: rtl/cross_bar_rr.sv
// N-master x M-slave crossbar: per-slave round-robin arbiter with grant lock on stall,
// combinational acknowledge and a one-cycle registered read-data return path.
module cross_bar_rr #(
    parameter int N_MASTERS = 4,
    parameter int N_SLAVES  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_cmd,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic [N_SLAVES-1:0]           s_req,
    output logic [N_SLAVES*ADDR_W-1:0]    s_addr,
    output logic [N_SLAVES-1:0]           s_cmd,
    output logic [N_SLAVES*DATA_W-1:0]    s_wdata,
    input  logic [N_SLAVES-1:0]           s_ack,
    input  logic [N_SLAVES*DATA_W-1:0]    s_rdata
);
    localparam int SEL_W = $clog2(N_SLAVES);
    localparam int MID_W = $clog2(N_MASTERS);
    localparam logic [MID_W-1:0] LAST_M = MID_W'(N_MASTERS - 1);

    logic [SEL_W-1:0]     tgt     [N_MASTERS];
    logic [N_MASTERS-1:0] r       [N_SLAVES];
    logic [MID_W-1:0]     gnt     [N_SLAVES];
    logic [MID_W-1:0]     ptr     [N_SLAVES];
    logic [MID_W-1:0]     lock_id [N_SLAVES];
    logic [N_SLAVES-1:0]  lock;
    logic [N_SLAVES-1:0]  rd_pend_p1;
    logic [MID_W-1:0]     rd_own_p1 [N_SLAVES];
    logic                 found;
    int                   idx;

    // Stage p0: decode, arbitration and forwarding (combinational)
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            tgt[i] = m_addr[i*ADDR_W + ADDR_W - SEL_W +: SEL_W];
        end
        for (int s = 0; s < N_SLAVES; s++) begin
            r[s] = '0;
            for (int i = 0; i < N_MASTERS; i++) begin
                r[s][i] = m_req[i] && (tgt[i] == SEL_W'(s));
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        idx     = 0;
        s_req   = '0;
        s_addr  = '0;
        s_cmd   = '0;
        s_wdata = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            gnt[s] = lock_id[s];
            if (!lock[s]) begin
                gnt[s] = ptr[s];
                found  = 1'b0;
                for (int k = 0; k < N_MASTERS; k++) begin
                    idx = (int'(ptr[s]) + k) % N_MASTERS;
                    if (!found && r[s][idx]) begin
                        gnt[s] = MID_W'(idx);
                        found  = 1'b1;
                    end
                end
            end
            s_req[s] = |r[s];
            if (s_req[s]) begin
                s_addr[s*ADDR_W +: ADDR_W]  = m_addr[int'(gnt[s])*ADDR_W +: ADDR_W];
                s_cmd[s]                    = m_cmd[gnt[s]];
                s_wdata[s*DATA_W +: DATA_W] = m_wdata[int'(gnt[s])*DATA_W +: DATA_W];
            end
        end
    end

    // Acknowledge is same-cycle; read return is driven from the p1 registers
    always_comb begin
        m_ack    = '0;
        m_rvalid = '0;
        m_rdata  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_ack[i] = m_req[i] && s_ack[tgt[i]] && (gnt[tgt[i]] == MID_W'(i));
        end
        for (int s = 0; s < N_SLAVES; s++) begin
            if (rd_pend_p1[s]) begin
                m_rvalid[rd_own_p1[s]] = 1'b1;
                m_rdata[int'(rd_own_p1[s])*DATA_W +: DATA_W] =
                    m_rdata[int'(rd_own_p1[s])*DATA_W +: DATA_W] | s_rdata[s*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p1: arbiter state update and read-return tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock       <= '0;
            rd_pend_p1 <= '0;
            for (int s = 0; s < N_SLAVES; s++) begin
                ptr[s]       <= '0;
                lock_id[s]   <= '0;
                rd_own_p1[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SLAVES; s++) begin
                rd_pend_p1[s] <= 1'b0;
                if (s_req[s]) begin
                    if (s_ack[s]) begin
                        ptr[s]  <= (gnt[s] == LAST_M) ? '0 : gnt[s] + 1'b1;
                        lock[s] <= 1'b0;
                        if (!s_cmd[s]) begin
                            rd_pend_p1[s] <= 1'b1;
                            rd_own_p1[s]  <= gnt[s];
                        end
                    end else begin
                        // Hold the grant so a stalled transfer cannot be pre-empted
                        lock[s]    <= 1'b1;
                        lock_id[s] <= gnt[s];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cross_bar_rr.sv
// Bench for cross_bar_rr: scripted vectors, corner sequences and random traffic
// checked against a priority-distance arbitration model.
module tb_cross_bar_rr;
    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_req;
    logic [NM*AW-1:0]  m_addr;
    logic [NM-1:0]     m_cmd;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     m_ack;
    logic [NM*DW-1:0]  m_rdata;
    logic [NM-1:0]     m_rvalid;
    logic [NS-1:0]     s_req;
    logic [NS*AW-1:0]  s_addr;
    logic [NS-1:0]     s_cmd;
    logic [NS*DW-1:0]  s_wdata;
    logic [NS-1:0]     s_ack;
    logic [NS*DW-1:0]  s_rdata;

    cross_bar_rr #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: next-priority master, held master, pending returns
    int            mptr  [NS];
    bit            mlk   [NS];
    int            mlid  [NS];
    bit            rv_q  [NM];
    int            rv_src[NM];
    logic [NM-1:0] last_ack;

    logic [NM-1:0]    obs_ack, obs_rv;
    logic [NS-1:0]    obs_sreq;
    logic [NM*DW-1:0] obs_rd;

    typedef struct {
        logic [3:0] req;
        logic [7:0] sel;
        logic [3:0] cmd;
        logic [3:0] sack;
        logic [3:0] eack;
        logic [3:0] esreq;
        logic [3:0] erv;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            mptr[s] = 0; mlk[s] = 0; mlid[s] = 0;
        end
        for (int i = 0; i < NM; i++) begin
            rv_q[i] = 0; rv_src[i] = 0;
        end
    endtask

    // Check one cycle at the falling edge, then advance the model across the rising edge
    task automatic step();
        logic [NM-1:0]    e_ack, e_rv;
        logic [NS-1:0]    e_sreq, e_scmd;
        logic [NS*AW-1:0] e_saddr;
        logic [NS*DW-1:0] e_swd;
        logic [NM*DW-1:0] e_rd;
        int g [NS];
        int best, tg, d;
        bit nrv [NM];
        int nsrc[NM];
        @(negedge clk);
        if (!rst_n) model_reset();
        e_ack = '0; e_rv = '0; e_sreq = '0; e_scmd = '0;
        e_saddr = '0; e_swd = '0; e_rd = '0;
        for (int s = 0; s < NS; s++) begin
            g[s] = -1;
            best = NM;
            for (int i = 0; i < NM; i++) begin
                tg = int'(m_addr[i*AW + AW - 2 +: 2]);
                if (m_req[i] && tg == s) begin
                    d = (i - mptr[s] + NM) % NM;
                    if (mlk[s]) begin
                        if (i == mlid[s]) g[s] = i;
                    end else if (d < best) begin
                        best = d; g[s] = i;
                    end
                end
            end
            if (g[s] >= 0) begin
                e_sreq[s] = 1'b1;
                e_scmd[s] = m_cmd[g[s]];
                e_saddr[s*AW +: AW] = m_addr[g[s]*AW +: AW];
                e_swd[s*DW +: DW]   = m_wdata[g[s]*DW +: DW];
            end
        end
        for (int i = 0; i < NM; i++) begin
            tg = int'(m_addr[i*AW + AW - 2 +: 2]);
            e_ack[i] = m_req[i] && (g[tg] == i) && s_ack[tg];
            if (rv_q[i]) begin
                e_rv[i] = 1'b1;
                e_rd[i*DW +: DW] = s_rdata[rv_src[i]*DW +: DW];
            end
        end
        obs_ack = m_ack; obs_rv = m_rvalid; obs_sreq = s_req; obs_rd = m_rdata;
        chk("m_ack", m_ack, e_ack);
        chk("s_req", s_req, e_sreq);
        chk("s_cmd", s_cmd, e_scmd);
        chk("s_addr", s_addr, e_saddr);
        chk("s_wdata", s_wdata, e_swd);
        chk("m_rvalid", m_rvalid, e_rv);
        chk("m_rdata", m_rdata, e_rd);
        last_ack = e_ack;
        for (int i = 0; i < NM; i++) begin nrv[i] = 0; nsrc[i] = 0; end
        if (rst_n) begin
            for (int s = 0; s < NS; s++) begin
                if (g[s] >= 0) begin
                    if (s_ack[s]) begin
                        mptr[s] = (g[s] + 1) % NM;
                        mlk[s]  = 0;
                        if (!m_cmd[g[s]]) begin nrv[g[s]] = 1; nsrc[g[s]] = s; end
                    end else begin
                        mlk[s] = 1; mlid[s] = g[s];
                    end
                end
            end
            for (int i = 0; i < NM; i++) begin rv_q[i] = nrv[i]; rv_src[i] = nsrc[i]; end
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req = '0; m_cmd = '0; s_ack = '0;
        m_addr = '0; m_wdata = '0; s_rdata = '0;
    endtask

    task automatic apply_row(input vec_t v);
        for (int i = 0; i < NM; i++) begin
            m_req[i] = v.req[i];
            m_cmd[i] = v.cmd[i];
            m_addr[i*AW +: AW]  = {v.sel[2*i +: 2], 30'(i * 64)};
            m_wdata[i*DW +: DW] = 32'h100 + 32'(i);
        end
        s_ack = v.sack;
        for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = 32'hC0DE0000 + 32'(s);
    endtask

    bit pend [NM];

    initial begin
        //             req      sel          cmd      sack     eack     esreq    erv
        tbl[0]  = '{4'b0000, 8'b00000000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 8'b00000001, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000};
        tbl[2]  = '{4'b0000, 8'b00000000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b1111, 8'b10101010, 4'b1111, 4'b0100, 4'b0001, 4'b0100, 4'b0000};
        tbl[4]  = '{4'b1111, 8'b10101010, 4'b1111, 4'b0100, 4'b0010, 4'b0100, 4'b0000};
        tbl[5]  = '{4'b1111, 8'b10101010, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        tbl[6]  = '{4'b1111, 8'b10101010, 4'b1111, 4'b0100, 4'b1000, 4'b0100, 4'b0000};
        tbl[7]  = '{4'b1111, 8'b10101010, 4'b1111, 4'b0100, 4'b0001, 4'b0100, 4'b0000};
        tbl[8]  = '{4'b0010, 8'b00000000, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[9]  = '{4'b0011, 8'b00000000, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[10] = '{4'b0011, 8'b00000000, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[11] = '{4'b0011, 8'b00000000, 4'b1111, 4'b0001, 4'b0010, 4'b0001, 4'b0000};
        tbl[12] = '{4'b0001, 8'b00000000, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        tbl[13] = '{4'b1000, 8'b11000000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        tbl[14] = '{4'b0000, 8'b00000000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        tbl[15] = '{4'b0001, 8'b00000001, 4'b0000, 4'b0010, 4'b0001, 4'b0010, 4'b0000};
        tbl[16] = '{4'b0100, 8'b00010000, 4'b0000, 4'b0010, 4'b0100, 4'b0010, 4'b0001};
        tbl[17] = '{4'b0000, 8'b00000000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[18] = '{4'b0011, 8'b00000100, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
        tbl[19] = '{4'b0000, 8'b00000000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};

        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        last_ack = '0;
        @(posedge clk);
        #1;
        repeat (5) step();
        rst_n = 1'b1;
        step();
        chk("idle_all_zero", {obs_ack, obs_rv, obs_sreq, obs_rd}, '0);

        for (int t = 0; t < 20; t++) begin
            apply_row(tbl[t]);
            step();
            chk($sformatf("row%0d_ack", t), obs_ack, tbl[t].eack);
            chk($sformatf("row%0d_sreq", t), obs_sreq, tbl[t].esreq);
            chk($sformatf("row%0d_rv", t), obs_rv, tbl[t].erv);
        end

        // Read return with a distinctive data word, valid for one cycle only
        idle_inputs();
        m_req[3] = 1'b1;
        m_addr[3*AW +: AW] = 32'hC000_0010;
        s_ack[3] = 1'b1;
        step();
        chk("rd_ack_m3", obs_ack, 4'b1000);
        idle_inputs();
        s_rdata[3*DW +: DW] = 32'hDEADBEEF;
        step();
        chk("rd_rvalid_m3", obs_rv, 4'b1000);
        chk("rd_rdata_m3", obs_rd[3*DW +: DW], 32'hDEADBEEF);
        step();
        chk("rd_rvalid_once", obs_rv, 4'b0000);

        // Parallel reads acked together, reset asserted before the capturing edge
        idle_inputs();
        m_req = 4'b0011;
        m_addr[0*AW +: AW] = 32'h0000_0004;
        m_addr[1*AW +: AW] = 32'h4000_0008;
        s_ack = 4'b0011;
        @(negedge clk);
        chk("par_ack", m_ack, 4'b0011);
        #2 rst_n = 1'b0;
        #1 chk("rst_rv_now", m_rvalid, 4'b0000);
        @(posedge clk);
        #1 chk("rst_rv_edge", m_rvalid, 4'b0000);
        idle_inputs();
        @(posedge clk);
        #1 chk("rst_rv_hold", m_rvalid, 4'b0000);
        rst_n = 1'b1;
        model_reset();
        last_ack = '0;
        step();
        chk("post_rst_rv", obs_rv, 4'b0000);

        // Random traffic obeying the hold-until-ack master rule
        for (int i = 0; i < NM; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (pend[i] && last_ack[i]) pend[i] = 0;
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1;
                    m_addr[i*AW +: AW]  = $urandom;
                    m_cmd[i]            = 1'($urandom_range(0, 1));
                    m_wdata[i*DW +: DW] = $urandom;
                end
                m_req[i] = pend[i];
            end
            s_ack = 4'($urandom_range(0, 15));
            for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
